// File: rtl/axi_ram_slave.sv
// AXI3-style 32-bit slave memory: independent read and write burst engines
// sharing one word-organised RAM with byte-enable writes and registered reads.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // FIXED bursts keep the address; INCR and WRAP both step by the beat size.
  function automatic logic [31:0] burst_step(input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? 32'd0 : (32'd1 << size);
  endfunction

  logic [31:0] mem [DEPTH];

  r_state_t    r_state_q;
  logic [31:0] r_addr_q;
  logic [3:0]  r_cnt_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_burst_q;
  logic [3:0]  rid_q;
  logic        arready_q, rvalid_q, rlast_q;
  logic [31:0] rdata_q;

  w_state_t    w_state_q;
  logic [31:0] w_addr_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q;
  logic [3:0]  bid_q;
  logic        awready_q, wready_q, bvalid_q;

  logic [31:0]           r_addr_d;
  logic                  rd_load;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  unused_ok;

  assign r_addr_d = r_addr_q + burst_step(r_size_q, r_burst_q);
  assign rd_load  = (arready_q && arvalid) || (rvalid_q && rready && (r_cnt_q != 4'd0));
  assign rd_idx   = arready_q ? araddr[ADDR_WIDTH+1:2] : r_addr_d[ADDR_WIDTH+1:2];
  assign wr_en    = (w_state_q == W_DATA) && wvalid && !reset;
  assign wr_idx   = w_addr_q[ADDR_WIDTH+1:2];
  assign unused_ok = ^awlen;

  // Non-blocking read and write on the same edge give read-before-write.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (rd_load) begin
      rdata_q <= mem[rd_idx];
    end
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wstrb[b]) begin
        mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
      r_addr_q  <= 32'd0;
      r_cnt_q   <= 4'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid) begin
            rid_q     <= arid;
            r_addr_q  <= araddr;
            r_cnt_q   <= arlen;
            r_size_q  <= arsize;
            r_burst_q <= arburst;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (arlen == 4'd0);
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_cnt_q != 4'd0) begin
              r_addr_q <= r_addr_d;
              r_cnt_q  <= r_cnt_q - 4'd1;
              rlast_q  <= (r_cnt_q == 4'd1);
            end else begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write bursts end on wlast alone; awlen plays no part in termination.
  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 4'd0;
      w_addr_q  <= 32'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid) begin
            bid_q     <= awid;
            w_addr_q  <= awaddr;
            w_size_q  <= awsize;
            w_burst_q <= awburst;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_addr_q <= w_addr_q + burst_step(w_size_q, w_burst_q);
            if (wlast) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = 2'b00;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: a word-indexed memory model supplies the
// expected read data, which is queued when an AR is issued and popped per beat.
module tb_axi_ram_slave;

  logic        aclk = 1'b0;
  logic        reset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_ram_slave #(.ADDR_WIDTH(14), .INIT_FILE("")) dut (
    .aclk(aclk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] got_data [$];
  bit          got_last [$];
  logic [3:0]  got_id [$];
  int stall_bad;
  int arready_hi;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FFF);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'h0;
  endfunction

  function automatic logic [31:0] bstep(input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b00) ? 32'd0 : (32'd1 << size);
  endfunction

  task automatic push_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst);
    logic [31:0] a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_q.push_back(mread(a));
      a = a + bstep(size, burst);
    end
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (arready !== 1'b1 && t < 50) begin step(); t++; end
    vectors++;
    if (t == 50) begin
      miscompares++;
      $display("FAIL ar_handshake: arready=%b required 1", arready);
    end
    step();
    arvalid = 1'b0;
  endtask

  // mode 0: rready always high; mode 1: rready pattern 1,0,0,1 repeating
  task automatic collect_r(input int n, input int mode);
    int c = 0;
    bit holding = 0;
    logic [31:0] held = 32'h0;
    got_data.delete(); got_last.delete(); got_id.delete();
    stall_bad = 0; arready_hi = 0;
    while (got_data.size() < n && c < 300) begin
      if (holding) begin
        if (rvalid !== 1'b1 || rdata !== held) stall_bad++;
        holding = 0;
      end
      rready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (rvalid === 1'b1) begin
        if (arready !== 1'b0) arready_hi++;
        if (rready) begin
          got_data.push_back(rdata); got_last.push_back(rlast); got_id.push_back(rid);
        end else begin
          holding = 1; held = rdata;
        end
      end
      step();
      c++;
    end
    rready = 1'b0;
    vectors++;
    if (got_data.size() != n) begin
      miscompares++;
      $display("FAIL r_beats: got %0d beats required %0d", got_data.size(), n);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                          input logic [1:0] burst, input int n, input logic [31:0] base,
                          input logic [3:0] strb, input int bdelay,
                          output logic [3:0] b_id, output logic [1:0] b_resp, output bit held_ok);
    int t = 0;
    logic [31:0] a = addr;
    logic [31:0] w;
    awid = id; awaddr = addr; awlen = 4'(n - 1); awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && t < 50) begin step(); t++; end
    vectors++;
    if (t == 50) begin
      miscompares++;
      $display("FAIL aw_handshake: awready=%b required 1", awready);
    end
    step();
    awvalid = 1'b0;
    for (int j = 0; j < n; j++) begin
      wdata = base + 32'(j); wstrb = strb; wlast = (j == n - 1); wvalid = 1'b1;
      t = 0;
      while (wready !== 1'b1 && t < 50) begin step(); t++; end
      vectors++;
      if (t == 50) begin
        miscompares++;
        $display("FAIL w_handshake: wready=%b required 1", wready);
      end
      step();
      w = mread(a);
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[widx(a)] = w;
      a = a + bstep(size, burst);
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (bvalid !== 1'b1 && t < 50) begin step(); t++; end
    vectors++;
    if (t == 50) begin
      miscompares++;
      $display("FAIL b_wait: bvalid=%b required 1", bvalid);
    end
    held_ok = 1;
    repeat (bdelay) begin
      step();
      if (bvalid !== 1'b1) held_ok = 0;
    end
    b_id = bid; b_resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    vectors++;
    if ({arready, awready} !== 2'b11) begin
      miscompares++; $display("FAIL reset_ready: {arready,awready}=%b required 11", {arready, awready});
    end
    vectors++;
    if ({rvalid, rlast, wready, bvalid} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_valids: {rvalid,rlast,wready,bvalid}=%b required 0000", {rvalid, rlast, wready, bvalid});
    end
    vectors++;
    if ({rid, bid, rdata} !== 40'h0) begin
      miscompares++; $display("FAIL reset_regs: rid=%h bid=%h rdata=%h required 0", rid, bid, rdata);
    end
    reset = 1'b0;
    step();
    $display("reset: checked ready/valid/id/data state");
  endtask

  task automatic test_single();
    logic [3:0] b_id; logic [1:0] b_resp; bit held_ok;
    do_write(32'h100, 4'h5, 3'd2, 2'b01, 1, 32'hDEADBEEF, 4'hF, 0, b_id, b_resp, held_ok);
    vectors++;
    if (b_id !== 4'h5 || b_resp !== 2'b00) begin
      miscompares++; $display("FAIL single_b: bid=%h bresp=%b required 5 00", b_id, b_resp);
    end
    exp_q.push_back(32'hDEADBEEF);
    send_ar(32'h100, 4'h3, 4'd0, 3'd2, 2'b01);
    vectors++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin
      miscompares++; $display("FAIL single_latency: rvalid=%b rresp=%b required 1 00", rvalid, rresp);
    end
    collect_r(1, 0);
    begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[0] !== e || got_last[0] !== 1'b1 || got_id[0] !== 4'h3) begin
        miscompares++;
        $display("FAIL single_read: data=%h last=%b id=%h required %h 1 3", got_data[0], got_last[0], got_id[0], e);
      end
    end
    vectors++;
    if (rvalid !== 1'b0) begin
      miscompares++; $display("FAIL single_end: rvalid=%b required 0", rvalid);
    end
    $display("single: write 0x100 then read back");
  endtask

  task automatic test_incr_burst();
    logic [3:0] b_id; logic [1:0] b_resp; bit held_ok;
    do_write(32'h40, 4'h1, 3'd2, 2'b01, 16, 32'h10, 4'hF, 0, b_id, b_resp, held_ok);
    push_read(32'h40, 15, 3'd2, 2'b01);
    send_ar(32'h40, 4'h7, 4'd15, 3'd2, 2'b01);
    collect_r(16, 0);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[i] !== e || got_data[i] !== 32'h10 + 32'(i)) begin
        miscompares++; $display("FAIL incr_data[%0d]: got %h required %h", i, got_data[i], e);
      end
      vectors++;
      if (got_last[i] !== (i == 15)) begin
        miscompares++; $display("FAIL incr_last[%0d]: got %b required %b", i, got_last[i], (i == 15));
      end
    end
    vectors++;
    if (arready_hi != 0) begin
      miscompares++; $display("FAIL incr_arready: high on %0d burst cycles required 0", arready_hi);
    end
    $display("incr_burst: 16 beats from 0x40");
  endtask

  task automatic test_strobes();
    logic [3:0] b_id; logic [1:0] b_resp; bit held_ok;
    do_write(32'h200, 4'h2, 3'd2, 2'b01, 1, 32'hFFFFFFFF, 4'hF, 0, b_id, b_resp, held_ok);
    do_write(32'h200, 4'h2, 3'd0, 2'b01, 1, 32'h000000AA, 4'b0001, 0, b_id, b_resp, held_ok);
    do_write(32'h300, 4'h4, 3'd2, 2'b00, 4, 32'hA0, 4'hF, 0, b_id, b_resp, held_ok);
    push_read(32'h200, 0, 3'd2, 2'b01);
    send_ar(32'h200, 4'h1, 4'd0, 3'd2, 2'b01);
    collect_r(1, 0);
    begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[0] !== e || got_data[0] !== 32'hFFFFFFAA) begin
        miscompares++; $display("FAIL strobe_byte: got %h required %h", got_data[0], e);
      end
    end
    push_read(32'h300, 0, 3'd2, 2'b01);
    send_ar(32'h300, 4'h1, 4'd0, 3'd2, 2'b01);
    collect_r(1, 0);
    begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[0] !== e || got_data[0] !== 32'hA3) begin
        miscompares++; $display("FAIL fixed_burst: got %h required %h", got_data[0], e);
      end
    end
    $display("strobes: byte lane and FIXED burst");
  endtask

  task automatic test_backpressure();
    logic [3:0] b_id; logic [1:0] b_resp; bit held_ok;
    do_write(32'h600, 4'h6, 3'd2, 2'b01, 4, 32'h6100, 4'hF, 5, b_id, b_resp, held_ok);
    vectors++;
    if (held_ok !== 1'b1 || b_id !== 4'h6) begin
      miscompares++; $display("FAIL b_backpressure: held=%b bid=%h required 1 6", held_ok, b_id);
    end
    push_read(32'h600, 3, 3'd2, 2'b01);
    send_ar(32'h600, 4'h9, 4'd3, 3'd2, 2'b01);
    collect_r(4, 1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[i] !== e || got_last[i] !== (i == 3) || got_id[i] !== 4'h9) begin
        miscompares++;
        $display("FAIL bp_beat[%0d]: data=%h last=%b id=%h required %h %b 9", i, got_data[i], got_last[i], got_id[i], e, (i == 3));
      end
    end
    vectors++;
    if (stall_bad != 0) begin
      miscompares++; $display("FAIL bp_stable: %0d unstable stall cycles required 0", stall_bad);
    end
    $display("backpressure: R stalls and B held 5 cycles");
  endtask

  task automatic test_collision();
    logic [3:0] b_id; logic [1:0] b_resp; bit held_ok;
    do_write(32'h4F0, 4'h1, 3'd2, 2'b01, 8, 32'h5000, 4'hF, 0, b_id, b_resp, held_ok);
    push_read(32'h4F0, 7, 3'd2, 2'b01);
    fork
      begin
        send_ar(32'h4F0, 4'h2, 4'd7, 3'd2, 2'b01);
        collect_r(8, 0);
      end
      begin
        logic [3:0] c_id; logic [1:0] c_resp; bit c_ok;
        do_write(32'h4F4, 4'hA, 3'd2, 2'b01, 4, 32'hC000, 4'hF, 0, c_id, c_resp, c_ok);
      end
    join
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[i] !== e || got_data[i] !== 32'h5000 + 32'(i)) begin
        miscompares++; $display("FAIL collide_old[%0d]: got %h required %h", i, got_data[i], e);
      end
    end
    push_read(32'h500, 0, 3'd2, 2'b01);
    send_ar(32'h500, 4'h2, 4'd0, 3'd2, 2'b01);
    collect_r(1, 0);
    begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[0] !== e || got_data[0] !== 32'hC003) begin
        miscompares++; $display("FAIL collide_new: got %h required %h", got_data[0], e);
      end
    end
    $display("collision: concurrent bursts around 0x500");
  endtask

  task automatic test_reset_mid();
    send_ar(32'h40, 4'h8, 4'd7, 3'd2, 2'b01);
    rready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    vectors++;
    if ({rvalid, arready, awready, bvalid} !== 4'b0110) begin
      miscompares++;
      $display("FAIL mid_reset: {rvalid,arready,awready,bvalid}=%b required 0110", {rvalid, arready, awready, bvalid});
    end
    reset = 1'b0;
    rready = 1'b0;
    step();
    push_read(32'h44, 1, 3'd2, 2'b01);
    send_ar(32'h44, 4'hB, 4'd1, 3'd2, 2'b01);
    collect_r(2, 0);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e = exp_q.pop_front();
      vectors++;
      if (got_data[i] !== e || got_last[i] !== (i == 1) || got_id[i] !== 4'hB) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: data=%h last=%b id=%h required %h %b b", i, got_data[i], got_last[i], got_id[i], e, (i == 1));
      end
    end
    $display("reset_mid: abort during beat 3 then new AR");
  endtask

  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobes();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
